// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Arbitrates the instruction-cache fill port and the data-cache port onto
//   the single RAM port inside the memory controller. A grant is registered
//   (one-cycle arbitration latency). The grant is held until the RAM reports
//   ACCESS or the owner withdraws its request. Each grant is followed by one
//   idle bubble cycle. Completed transfers are counted per requester.
//
// Ports
//   CLK, nRST                      clock, synchronous active-low reset
//   iREN, iaddr / iwait, iload     icache read port (iwait low = data valid)
//   dREN, dWEN, daddr, dstore      dcache request (dWEN overrides dREN)
//   dwait, dload                   dcache completion / read data
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   single RAM port (ramstate 0 FREE,
//                                  1 BUSY, 2 ACCESS, 3 ERROR)
//   icount, dcount                 completed-transfer counters (wrapping)
module cache_mem_arbiter #(
  parameter bit FAIR_ARB = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  output logic             iwait,
  output logic [31:0]      iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t state, next_state;
  logic   i_first, next_i_first;  // 1 = icache wins the next simultaneous request
  logic   i_done, d_done;
  logic   d_req;

  assign d_req = dREN | dWEN;

  // Load data is passed straight through; it is only meaningful while the
  // matching wait is low.
  assign iload = ramload;
  assign dload = ramload;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset is synchronous, so it sits inside
  // the clocked branch.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      i_first <= 1'b0;
      icount  <= '0;
      dcount  <= '0;
    end else begin
      state   <= next_state;
      i_first <= next_i_first;
      if (i_done) icount <= icount + 1'b1;
      if (d_done) dcount <= dcount + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    next_i_first = i_first;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    i_done       = 1'b0;
    d_done       = 1'b0;

    case (state)
      IDLE: begin
        // The data cache wins unless fair arbitration has handed the turn to
        // the instruction cache after a contended data access.
        if (d_req && !(iREN && FAIR_ARB && i_first)) next_state = DGRANT;
        else if (iREN)                               next_state = IGRANT;
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (ramstate == RAM_ACCESS) begin
          dwait        = 1'b0;
          d_done       = 1'b1;
          next_state   = IDLE;
          next_i_first = iREN;
        end else if (!d_req) begin
          // Withdrawn before completion: release the port at once, no count.
          ramaddr    = '0;
          ramstore   = '0;
          next_state = IDLE;
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (ramstate == RAM_ACCESS) begin
          iwait        = 1'b0;
          i_done       = 1'b1;
          next_state   = IDLE;
          next_i_first = 1'b0;
        end else if (!iREN) begin
          ramaddr    = '0;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache, inside the memory controller.
- Arbitrates the icache fill port (iREN/iaddr) and the dcache port (dREN/dWEN/daddr/dstore) onto the single RAM port.
- Returns iwait/dwait and load data to the caches.
- Counts completed transfers per requester for performance reporting.

Parameters:
- FAIR_ARB, 1: 1 = alternate priority after a data access when both caches are pending; 0 = data cache always wins.
- CNT_W, 32: width of the access counters.

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  synchronous active-low reset, sampled on CLK rising edge
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the cycle icache read data is valid
- iload  out  32  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request (overrides dREN)
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the cycle the dcache access completes
- dload  out  32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- icount  out  CNT_W  completed icache transfers
- dcount  out  CNT_W  completed dcache transfers

Behaviour:
- Clock and reset: one clock CLK; reset nRST is synchronous and active-low. Reset is applied at the CLK edge where nRST=0.
- Reset values: state IDLE, priority flag = data-first, icount=0, dcount=0.
- Outputs during and after reset until a grant: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- States: IDLE, IGRANT, DGRANT.
- IDLE: RAM controls all 0; iwait=dwait=1. Arbitration at the edge:
  - dREN|dWEN only -> DGRANT.
  - iREN only -> IGRANT.
  - Both pending -> DGRANT unless FAIR_ARB=1 and the priority flag is instruction-first, then IGRANT.
  - None pending -> stay IDLE.
- Arbitration latency: one cycle; grant is registered, so RAM signals assert the cycle after the request is first seen in IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
  - dwait = ~(ramstate==ACCESS), combinational; dload=ramload.
  - iwait=1.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - iwait = ~(ramstate==ACCESS), combinational; iload=ramload.
  - dwait=1.
- Completion: the cycle ramstate==ACCESS in a grant state.
  - Owner's counter increments by 1 and wraps modulo 2^CNT_W.
  - Next state IDLE; one idle bubble cycle between transfers.
  - Priority flag after a DGRANT completion: instruction-first if iREN is pending that cycle, else data-first.
  - Priority flag after an IGRANT completion: data-first.
- BUSY or FREE in a grant state: hold state and outputs; owner wait stays 1; no timeout.
- ERROR in a grant state: treated as not-ready. Wait stays 1, state held, request reissued every cycle until ACCESS.
- Request withdrawn mid-grant (owner's enables both 0 with ramstate != ACCESS):
  - RAM controls drop combinationally that cycle.
  - Next state IDLE; no count.
- The non-owner's request is never dropped, only delayed. A new dcache request during IGRANT waits for IGRANT to complete.
- iload and dload are undefined (pass ramload) when their wait is 1.
- Reset mid-transfer: next cycle IDLE, all RAM controls 0, counters 0, no completion reported.

Test Plan:
- iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN high from cycle 1; iwait=0 and iload=0xDEADBEEF only in the ACCESS cycle; icount=1.
- dWEN=1 and dREN=1, daddr=0x80, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramaddr=0x80, ramstore=0x12345678; dwait=0 on ACCESS; dcount=1.
- iREN and dREN held together, FAIR_ARB=1, RAM answers in 1 cycle -> grant order D, I, D, I.
- Same stimulus with FAIR_ARB=0 -> D granted every time; icount stays 0.
- ramstate=ERROR for 3 cycles during DGRANT, then ACCESS -> dwait=1 through the error cycles; dwait=0 once; dcount increments once.
- nRST=0 pulsed during IGRANT with ramstate BUSY -> next cycle ramREN=0, iwait=1, icount=0, state IDLE.
- dREN dropped in DGRANT before ACCESS -> RAM controls 0 that cycle; return to IDLE; dcount unchanged.
